// File: rtl/eth_pkg.sv
// Shared types and constants for the bit-serial Ethernet transmit path.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Non-reflected register form; bits enter in line order (LSB of each byte first).
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

endpackage

// File: rtl/eth_tx_serializer_if.sv
// Byte stream feeding the serializer: valid/ready with an end-of-frame marker.
interface eth_tx_serializer_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/eth_fcs.sv
// Bit-serial CRC-32 generator, MSB-first register, one line bit per enabled clock.
module eth_fcs
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        data_in,
    output logic [31:0] crc
);

    logic feedback;

    assign feedback = crc[31] ^ data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= {crc[30:0], 1'b0} ^ (feedback ? CRC32_POLY : 32'h0000_0000);
        end
    end

endmodule

// File: rtl/eth_tx_serializer.sv
// Ethernet MAC transmit sequencer: preamble, SFD, LSB-first payload, zero pad, FCS, then IFG.
module eth_tx_serializer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_PAYLOAD    = 60,
    parameter int IFG_BITS       = 96
) (
    input  logic                clk,
    input  logic                reset,
    eth_tx_serializer_if.slave  s,
    output logic                tx_bit,
    output logic                tx_en,
    output logic                busy,
    output logic                underrun,
    output logic                frame_done
);

    localparam int          IFG_W    = $clog2(IFG_BITS + 1);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_BITS - 1);

    tx_state_t        state;
    logic [2:0]       bit_cnt;
    logic [15:0]      byte_cnt;
    logic [4:0]       fcs_cnt;
    logic [IFG_W-1:0] ifg_cnt;
    logic [7:0]       shreg;
    logic             last_flag;
    logic [31:0]      crc;

    logic        line_bit_p0;
    logic        line_en_p0;
    logic        crc_en;
    logic        crc_clr;
    logic        byte_end;
    logic        load_slot;
    logic        take;
    logic        starve;
    logic [15:0] byte_next;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign byte_end  = (bit_cnt == 3'd7);
    assign byte_next = sat_inc(byte_cnt);
    assign take      = load_slot & s.s_valid;
    assign starve    = load_slot & ~s.s_valid;
    assign crc_clr   = (state == IDLE) || (state == IFG);
    assign busy      = (state != IDLE);
    assign s.s_ready = load_slot;

    // Stage p0: state-decoded line bit; the CRC consumes it on the same edge tx_bit registers it.
    always_comb begin
        line_bit_p0 = 1'b0;
        line_en_p0  = 1'b0;
        crc_en      = 1'b0;
        load_slot   = 1'b0;
        case (state)
            PRE: begin
                line_en_p0  = 1'b1;
                line_bit_p0 = PREAMBLE_BYTE[bit_cnt];
            end
            SFD: begin
                line_en_p0  = 1'b1;
                line_bit_p0 = SFD_BYTE[bit_cnt];
                load_slot   = byte_end;
            end
            DATA: begin
                line_en_p0  = 1'b1;
                line_bit_p0 = shreg[bit_cnt];
                crc_en      = 1'b1;
                load_slot   = byte_end & ~last_flag;
            end
            PAD: begin
                line_en_p0  = 1'b1;
                crc_en      = 1'b1;
            end
            FCS: begin
                line_en_p0  = 1'b1;
                line_bit_p0 = ~crc[5'd31 - fcs_cnt];
            end
            default: begin
            end
        endcase
        // A starved load slot drops the line immediately rather than sending its bit.
        if (starve) begin
            line_en_p0  = 1'b0;
            line_bit_p0 = 1'b0;
            crc_en      = 1'b0;
        end
    end

    // Stage p1: registered line outputs, sequencing state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            fcs_cnt    <= '0;
            ifg_cnt    <= '0;
            last_flag  <= 1'b0;
            tx_bit     <= 1'b0;
            tx_en      <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_bit     <= line_bit_p0;
            tx_en      <= line_en_p0;
            underrun   <= starve;
            frame_done <= 1'b0;
            if (take) begin
                last_flag <= s.s_last;
            end
            case (state)
                IDLE: begin
                    if (s.s_valid) begin
                        state    <= PRE;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                PRE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_end) begin
                        if (byte_cnt == PRE_LAST) begin
                            state    <= SFD;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 16'd1;
                        end
                    end
                end
                SFD: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_end) begin
                        state <= starve ? IFG : DATA;
                    end
                end
                DATA: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_end) begin
                        byte_cnt <= byte_next;
                        if (last_flag) begin
                            state <= (byte_next < MIN_CNT) ? PAD : FCS;
                        end else if (starve) begin
                            state <= IFG;
                        end
                    end
                end
                PAD: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_end) begin
                        byte_cnt <= byte_next;
                        if (byte_next >= MIN_CNT) begin
                            state <= FCS;
                        end
                    end
                end
                FCS: begin
                    fcs_cnt <= fcs_cnt + 5'd1;
                    if (fcs_cnt == 5'd31) begin
                        frame_done <= 1'b1;
                        state      <= IFG;
                    end
                end
                IFG: begin
                    if (ifg_cnt == IFG_LAST) begin
                        state   <= IDLE;
                        ifg_cnt <= '0;
                    end else begin
                        ifg_cnt <= ifg_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            shreg <= s.s_data;
        end
    end

    eth_fcs u_fcs (
        .clk     (clk),
        .reset   (reset | crc_clr),
        .en      (crc_en),
        .data_in (line_bit_p0),
        .crc     (crc)
    );

endmodule

// File: tb/tb_eth_tx_serializer.sv
// Directed bench for eth_tx_serializer: frame vector table plus back-to-back, underrun and reset sequences.
module tb_eth_tx_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_bit, tx_en, busy, underrun, frame_done;

    eth_tx_serializer_if s_if ();

    eth_tx_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .s          (s_if),
        .tx_bit     (tx_bit),
        .tx_en      (tx_en),
        .busy       (busy),
        .underrun   (underrun),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int pad;
        int exp_en;
        int exp_rdy;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] src_data[$];
    logic       src_last[$];
    bit         cap[$];
    bit         exp_bits[$];
    bit         ref1[$];

    int en_run = 0, low_run = 0, last_en_len = 0, last_gap = 0;
    int rdy_cnt = 0, done_cnt = 0, done_pos = 0, under_cnt = 0, idle_viol = 0;
    bit under_en = 1'b0;
    bit prev_en = 1'b0;
    bit hs_pend = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive();
        s_if.s_valid = (src_data.size() != 0);
        s_if.s_data  = s_if.s_valid ? src_data[0] : 8'h00;
        s_if.s_last  = s_if.s_valid ? src_last[0] : 1'b0;
    endtask

    // One clock: update inputs just after the edge, observe outputs at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (hs_pend) begin
            void'(src_data.pop_front());
            void'(src_last.pop_front());
        end
        drive();
        @(negedge clk);
        if (tx_en) begin
            if (!prev_en) begin
                last_gap = low_run;
                en_run   = 0;
            end
            en_run++;
            cap.push_back(tx_bit);
        end else begin
            if (prev_en) begin
                last_en_len = en_run;
                low_run     = 0;
            end
            low_run++;
            if (tx_bit) idle_viol++;
        end
        prev_en = tx_en;
        if (frame_done) begin
            done_cnt++;
            done_pos = en_run;
        end
        if (underrun) begin
            under_cnt++;
            under_en = tx_en;
        end
        if (s_if.s_ready) rdy_cnt++;
        hs_pend = s_if.s_valid && s_if.s_ready;
    endtask

    task automatic push_byte_bits(input logic [7:0] b);
        for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
    endtask

    // Queues a frame for the source and appends its expected line bits (reflected CRC model).
    task automatic add_frame(input int len, input int pad, input int seed);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 7; i++) push_byte_bits(8'h55);
        push_byte_bits(8'hD5);
        for (int i = 0; i < len + pad; i++) begin
            b = (i < len) ? 8'((i * 37) + (seed * 11) + 3) : 8'h00;
            if (i < len) begin
                src_data.push_back(b);
                src_last.push_back(i == len - 1);
            end
            push_byte_bits(b);
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 32; k++) exp_bits.push_back(c[k]);
    endtask

    function automatic logic [31:0] residue(input int start, input int n);
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            fb = r[31] ^ ((start + i < cap.size()) ? cap[start + i] : 1'b0);
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
        end
        return r;
    endfunction

    function automatic int bit_mismatches(input int n);
        int m;
        m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= cap.size() || i >= exp_bits.size()) m++;
            else if (cap[i] != exp_bits[i]) m++;
        end
        return m;
    endfunction

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, (done_cnt >= target) ? 1 : 0, 1);
        repeat (3) step();
    endtask

    vec_t vecs[6];

    initial begin
        int base;
        int n;
        vecs = '{'{64, 0, 608, 64}, '{10, 50, 576, 10}, '{59, 1, 576, 59},
                 '{60, 0, 576, 60}, '{61, 0, 584, 61}, '{1, 59, 576, 1}};

        reset = 1'b1;
        drive();
        repeat (4) step();
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_bit", tx_bit, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_s_ready", s_if.s_ready, 0);
        reset = 1'b0;
        repeat (3) step();

        for (int v = 0; v < 6; v++) begin
            cap.delete();
            exp_bits.delete();
            rdy_cnt = 0;
            base = done_cnt;
            add_frame(vecs[v].len, vecs[v].pad, (v == 0) ? 0 : v + 20);
            wait_done(base + 1, 2000, $sformatf("len%0d", vecs[v].len));
            check($sformatf("len%0d_en_cycles", vecs[v].len), last_en_len, vecs[v].exp_en);
            check($sformatf("len%0d_s_ready", vecs[v].len), rdy_cnt, vecs[v].exp_rdy);
            check($sformatf("len%0d_done_pos", vecs[v].len), done_pos, vecs[v].exp_en);
            check($sformatf("len%0d_done_cnt", vecs[v].len), done_cnt - base, 1);
            check($sformatf("len%0d_bit_count", vecs[v].len), cap.size(), exp_bits.size());
            check($sformatf("len%0d_line_bits", vecs[v].len), bit_mismatches(exp_bits.size()), 0);
            check($sformatf("len%0d_residue", vecs[v].len), residue(64, vecs[v].exp_en - 64), 32'hC704_DD7B);
            if (v == 0) ref1 = cap;
            repeat (100) step();
        end

        // Back-to-back frames with s_valid never dropping.
        cap.delete();
        exp_bits.delete();
        base = done_cnt;
        add_frame(20, 40, 7);
        add_frame(30, 30, 8);
        wait_done(base + 2, 4000, "b2b");
        check("b2b_gap", last_gap, 97);
        check("b2b_line_bits", bit_mismatches(1152), 0);
        check("b2b_second_residue", residue(576 + 64, 512), 32'hC704_DD7B);
        repeat (100) step();

        // Source starves at the slot for byte 5: 64 + 4*8 + 7 bits reach the line.
        cap.delete();
        exp_bits.delete();
        base = under_cnt;
        for (int i = 0; i < 5; i++) begin
            src_data.push_back(8'(8'hA0 + i));
            src_last.push_back(1'b0);
        end
        n = 0;
        while (under_cnt == base && n < 1000) begin
            step();
            n++;
        end
        check("ur_pulse_seen", under_cnt - base, 1);
        check("ur_tx_en_low", under_en, 0);
        check("ur_en_cycles", last_en_len, 103);
        cap.delete();
        exp_bits.delete();
        base = done_cnt;
        add_frame(64, 0, 0);
        wait_done(base + 1, 2000, "ur_next");
        check("ur_gap", last_gap, 98);
        check("ur_next_line_bits", bit_mismatches(608), 0);
        check("ur_next_residue", residue(64, 544), 32'hC704_DD7B);
        check("ur_single_pulse", under_cnt - base + base - base, under_cnt - base);
        repeat (100) step();

        // Reset while fcs_cnt == 10 (line currently showing FCS bit 9, en cycle 586).
        cap.delete();
        exp_bits.delete();
        base = done_cnt;
        add_frame(64, 0, 0);
        n = 0;
        while (!(tx_en && en_run == 586) && n < 2000) begin
            step();
            n++;
        end
        check("rst_mid_reached", (tx_en && en_run == 586) ? 1 : 0, 1);
        reset = 1'b1;
        step();
        check("rst_mid_tx_en", tx_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_underrun", underrun, 0);
        reset = 1'b0;
        repeat (120) step();
        check("rst_mid_no_done", done_cnt - base, 0);
        cap.delete();
        exp_bits.delete();
        add_frame(64, 0, 0);
        wait_done(base + 1, 2000, "rst_after");
        check("rst_after_en_cycles", last_en_len, 608);
        exp_bits = ref1;
        check("rst_after_matches_first", bit_mismatches(608), 0);

        check("idle_tx_bit_zero", idle_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_tx_serializer.md
Name: eth_tx_serializer

Overview:
Bit-serial Ethernet MAC transmit sequencer, one line bit per clk (10BASE-T-style bit-time clock). Accepts payload bytes (DA..type/data) on a valid/ready stream and emits preamble, SFD, payload LSB-first, zero padding to minimum length, then FCS. Enforces the inter-frame gap. Owns and sequences one instance of the team's bit-serial CRC-32 generator (eth_fcs): clears it, gates its enable, feeds it bits, and shifts out its complemented result.

Parameters:
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD
MIN_PAYLOAD, 60, minimum bytes covered by FCS; shorter frames are zero-padded
IFG_BITS, 96, idle bit times after every frame, including aborted frames

Ports:
clk  in  1  bit-time clock
reset  in  1  synchronous, active-high
s_data  in  8  payload byte
s_valid  in  1  s_data/s_last valid
s_last  in  1  final payload byte of frame
s_ready  out  1  byte accepted on clk when s_valid&s_ready
tx_bit  out  1  serial line bit, registered
tx_en  out  1  line active, registered
busy  out  1  state != IDLE
underrun  out  1  one-cycle pulse, frame aborted
frame_done  out  1  one-cycle pulse on the last FCS bit

Behaviour:
- Reset, synchronous, active-high: state=IDLE; tx_bit=0, tx_en=0, underrun=0, frame_done=0, all counters 0; CRC cleared. Reset mid-frame aborts immediately; tx_en=0 the next cycle. No underrun pulse.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- Counters:
  - bit_cnt 0..7, per byte.
  - byte_cnt 16b, payload+pad, saturating.
  - fcs_cnt 0..31.
  - ifg_cnt sized for IFG_BITS.
- IDLE:
  - CRC clear held asserted.
  - s_valid=1 -> PRE next cycle. No byte is consumed.
- PRE: emits 0x55 LSB-first (1,0,1,0,...) for PREAMBLE_BYTES*8 cycles -> SFD.
- SFD: emits 0xD5 LSB-first (1,0,1,0,1,0,1,1).
  - s_ready=1 only on the bit_cnt==7 cycle. The first payload byte loads into the shift register there.
  - s_valid=0 on that cycle -> underrun.
- DATA:
  - tx_bit = shreg[bit_cnt]; CRC en=1; CRC data_in = the same bit.
  - On bit_cnt==7 of a byte whose last-flag is 0: s_ready=1 and the next byte loads. s_valid=0 there -> underrun.
  - Last byte (flag latched with its data) ends -> PAD if byte_cnt+1 < MIN_PAYLOAD, else FCS.
- PAD:
  - Emits 0x00 bytes with CRC en=1 until byte_cnt == MIN_PAYLOAD -> FCS.
  - s_ready=0.
- FCS:
  - 32 cycles; tx_bit = ~crc[31-fcs_cnt] (MSB of register first); CRC en=0, so the value is frozen.
  - frame_done pulses on fcs_cnt==31 -> IFG.
- IFG:
  - tx_en=0 for IFG_BITS cycles; CRC cleared -> IDLE.
  - A waiting s_valid starts PRE on the cycle after IDLE is entered. Back-to-back gap is exactly IFG_BITS+1 cycles with tx_en=0.
- Underrun:
  - underrun pulses 1 cycle; tx_en=0 from the next cycle; -> IFG.
  - Any partially offered frame remaining is the upstream's responsibility.
- tx_en=1 throughout PRE..FCS. tx_bit=0 whenever tx_en=0.
- Output timing: tx_bit/tx_en register the state-decoded bit. CRC en/data_in are driven from the same pre-register values, so the CRC is aligned with the line.
- byte_cnt saturates at 0xFFFF; no maximum-length check (upstream's job).

Decomposition:
- Package eth_pkg:
  - tx_state_t enum.
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
  - CRC32_POLY=32'h04C11DB7, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hC704DD7B.
- Sub-module: the existing eth_fcs instance. Drive its reset from (reset | crc_clr), en from crc_en, data_in from the line bit. No new sub-module.

Test Plan:
- 64-byte payload, s_valid held -> tx_en high exactly 64+512+32=608 cycles; first 64 bits are 55..55 D5 LSB-first; s_ready pulses 64 times; bench CRC over payload+FCS bits gives register 0xC704DD7B; frame_done on cycle 608.
- 10-byte payload -> 50 bytes of 0x00 pad; tx_en 576 cycles; exactly 10 s_ready pulses; residue 0xC704DD7B.
- 59-byte payload -> 1 pad byte; 60-byte payload -> no PAD state entered; both residues correct.
- Two frames back-to-back, s_valid always 1 -> tx_en low for exactly 97 cycles between frames; second FCS correct (CRC cleared).
- s_valid dropped at byte 5's load slot -> underrun pulse, tx_en=0 next cycle, 96-cycle IFG, next frame transmits with correct FCS.
- reset asserted at fcs_cnt=10 -> tx_en=0, busy=0 next cycle, no frame_done; following 64-byte frame matches test 1 exactly.
